// File: rtl/blink_pkg.sv
// Shared constants and state encoding for the Blink-64 stream driver.
package blink_pkg;

    localparam int BLINK_N      = 64;
    localparam int BLINK_TWEAK  = 128;
    localparam int BLINK_KEYLEN = 448;
    localparam int BLINK_BUS    = 32;

    localparam logic [1:0] OP_LOAD_KEY = 2'd0;
    localparam logic [1:0] OP_ENC      = 2'd1;
    localparam logic [1:0] OP_DEC      = 2'd2;
    localparam logic [1:0] OP_ZERO     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_TWK,
        ST_DAT,
        ST_WAIT,
        ST_OUT0,
        ST_OUT1
    } state_t;

endpackage

// File: rtl/blink_word_deser.sv
// Shift-in deserialiser: bus words enter at the top so the first word ends up
// in the low bits; "next" exposes the value after the current shift.
module blink_word_deser
    import blink_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       shift,
    input  logic [BLINK_BUS-1:0]       din,
    output logic [WORDS*BLINK_BUS-1:0] next,
    output logic                       last
);

    logic [WORDS*BLINK_BUS-1:0] data;
    logic [3:0]                 count;

    assign next = {din, data[WORDS*BLINK_BUS-1:BLINK_BUS]};
    assign last = (count == 4'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (shift) begin
            data  <= next;
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/blink_stream_driver.sv
// Stream front end for the Blink-64 core: frames in, staged operands, result out.
// Optional macro BLINK_STREAM_DRIVER_ZEROIZE_EN turns opcode 3 into key zeroize.
//
// state | meaning
// IDLE  | waiting for a header word
// KEY   | receiving 14 key words into staging
// TWK   | receiving 4 tweak words
// DAT   | receiving 2 data words; last word launches the core
// WAIT  | core pipeline latency
// OUT0  | low result word on m_data
// OUT1  | high result word on m_data
module blink_stream_driver
    import blink_pkg::*;
#(
    parameter int CORE_LAT  = 2,
    parameter int KEY_WORDS = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [BLINK_BUS-1:0]    s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BLINK_BUS-1:0]    m_data,
    output logic                    err,
    output logic                    key_valid,
    output logic                    core_enc,
    output logic [BLINK_KEYLEN-1:0] core_K0,
    output logic [BLINK_TWEAK-1:0]  core_T,
    output logic [BLINK_N-1:0]      core_P,
    input  logic [BLINK_N-1:0]      core_C
);

    localparam int TD_WORDS = (BLINK_TWEAK + BLINK_N) / BLINK_BUS;

    state_t                          state, state_n;
    logic [3:0]                      cnt, cnt_n;
    logic                            live, acc, hdr, fire_key, fire_td;
    logic                            key_last, td_last, enc_stage;
    logic [1:0]                      op;
    logic [KEY_WORDS*BLINK_BUS-1:0]  key_next;
    logic [TD_WORDS*BLINK_BUS-1:0]   td_next;
    logic [BLINK_KEYLEN-1:0]         key_q;
    logic [BLINK_N-1:0]              result;

    assign s_ready  = live && (state inside {ST_IDLE, ST_KEY, ST_TWK, ST_DAT});
    assign acc      = s_valid && s_ready;
    assign op       = s_data[1:0];
    assign hdr      = acc && (state == ST_IDLE);
    assign fire_key = acc && (state == ST_KEY) && key_last;
    assign fire_td  = acc && (state == ST_DAT) && td_last;

    assign m_valid  = (state == ST_OUT0) || (state == ST_OUT1);
    assign m_data   = (state == ST_OUT0) ? result[31:0] :
                      (state == ST_OUT1) ? result[63:32] : '0;
    assign core_K0  = key_q;

    blink_word_deser #(.WORDS(KEY_WORDS)) u_key_deser (
        .clk   (clk),
        .rst   (rst),
        .clr   (hdr),
        .shift (acc && (state == ST_KEY)),
        .din   (s_data),
        .next  (key_next),
        .last  (key_last)
    );

    blink_word_deser #(.WORDS(TD_WORDS)) u_td_deser (
        .clk   (clk),
        .rst   (rst),
        .clr   (hdr),
        .shift (acc && ((state == ST_TWK) || (state == ST_DAT))),
        .din   (s_data),
        .next  (td_next),
        .last  (td_last)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (acc) begin
                if (op == OP_LOAD_KEY)                 state_n = ST_KEY;
                else if (op == OP_ENC || op == OP_DEC) state_n = ST_TWK;
            end
            ST_KEY:  if (fire_key) state_n = ST_IDLE;
            ST_TWK:  if (acc && cnt == 4'd3) state_n = ST_DAT;
            ST_DAT:  if (fire_td) state_n = key_valid ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (cnt == 4'(CORE_LAT)) state_n = ST_OUT0;
            ST_OUT0: if (m_ready) state_n = ST_OUT1;
            ST_OUT1: if (m_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        cnt_n = cnt;
        if (state_n != state)                cnt_n = '0;
        else if (acc || state == ST_WAIT)    cnt_n = cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            live      <= 1'b0;
            err       <= 1'b0;
            key_valid <= 1'b0;
            key_q     <= '0;
            enc_stage <= 1'b0;
            core_enc  <= 1'b0;
            core_T    <= '0;
            core_P    <= '0;
            result    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            live  <= 1'b1;
            err   <= 1'b0;

            if (hdr) enc_stage <= (op == OP_ENC);

            if (fire_key) begin
                key_q     <= key_next;
                key_valid <= 1'b1;
            end

            // Without a key the frame is swallowed and the core is left untouched.
            if (fire_td) begin
                if (key_valid) begin
                    core_T   <= td_next[BLINK_TWEAK-1:0];
                    core_P   <= td_next[BLINK_TWEAK+BLINK_N-1:BLINK_TWEAK];
                    core_enc <= enc_stage;
                end else begin
                    err <= 1'b1;
                end
            end

            if (state == ST_WAIT && cnt == 4'(CORE_LAT)) result <= core_C;

            if (hdr && op == OP_ZERO) begin
`ifdef BLINK_STREAM_DRIVER_ZEROIZE_EN
                key_q     <= '0;
                key_valid <= 1'b0;
                core_T    <= '0;
                core_P    <= '0;
`else
                err <= 1'b1;
`endif
            end
        end
    end

endmodule
